// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one DATA_WIDTH-bit frame per accepted i_start, MSB first.
// SCLK half-period is CLK_DIV system clocks. DATA_WIDTH must be at least 2.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds i_loopback, which lets the
// receive path sample o_spi_mosi instead of i_spi_miso.
module spi_master_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                  i_loopback,
`endif
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_spi_cs,
  output logic                  o_spi_sclk,
  output logic                  o_spi_mosi,
  input  logic                  i_spi_miso
);

  localparam int unsigned    BCW      = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [7:0]     DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(2 * DATA_WIDTH - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            div_q, div_d;
  logic [BCW-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rxw_q, rxw_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_q, cs_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  half_end;
  logic                  rx_in;

  assign half_end = (div_q == DIV_LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_in = i_loopback ? mosi_q : i_spi_miso;
`else
  assign rx_in = i_spi_miso;
`endif

  // State register plus all datapath and output registers, synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxw_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxw_q   <= rxw_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: each non-idle phase ends when the divider reaches its last count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = SETUP;
      SETUP:   if (half_end) state_d = XFER;
      XFER:    if (half_end && (bit_q == BIT_LAST)) state_d = HOLD;
      HOLD:    if (half_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, shifters and output next values. Status outputs are decoded from
  // state_d so the registered copies line up with the state they describe.
  always_comb begin
    div_d = div_q + 8'd1;
    if ((state_q == IDLE) || (state_d != state_q) || half_end) div_d = '0;

    bit_d = bit_q;
    if (state_q != XFER)  bit_d = '0;
    else if (half_end)    bit_d = bit_q + BIT_ONE;

    tx_d   = tx_q;
    rx_d   = rx_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          tx_d   = i_tx_data;
          mosi_d = i_tx_data[DATA_WIDTH-1];
          rx_d   = '0;
        end
      end
      XFER: begin
        if (half_end) begin
          sclk_d = ~sclk_q;
          if (!bit_q[0]) begin
            rx_d = {rx_q[DATA_WIDTH-2:0], rx_in};
          end else if (bit_q != BIT_LAST) begin
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
            mosi_d = tx_q[DATA_WIDTH-2];
          end
        end
      end
      default: ;
    endcase

    cs_d   = (state_d == IDLE) || (state_d == DONE);
    busy_d = !cs_d;
    done_d = (state_d == DONE);
    rxw_d  = rxw_q;
    if (state_d == DONE) rxw_d = rx_q;
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rx_data  = rxw_q;
  assign o_spi_cs   = cs_q;
  assign o_spi_sclk = sclk_q;
  assign o_spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a default instance (8 bits, CLK_DIV=4) and a
// CLK_DIV=1 instance, each with a behavioural mode-0 slave and a bus monitor.
module tb_spi_master_ctrl;

  localparam int unsigned EXP0 = 4 * (2 * 8 + 2);
  localparam int unsigned EXP1 = 1 * (2 * 8 + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic       rst0 = 1'b0, start0 = 1'b0, busy0, done0, cs0, sclk0, mosi0, miso0;
  logic [7:0] tx0 = 8'h00, rx0;
  logic       rst1 = 1'b0, start1 = 1'b0, busy1, done1, cs1, sclk1, mosi1, miso1;
  logic [7:0] tx1 = 8'h00, rx1;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic       lb0 = 1'b0;
  logic       lb1 = 1'b0;
`endif

  spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(4)) u_dut (
    .i_clk(clk), .i_rst(rst0), .i_start(start0), .i_tx_data(tx0),
`ifdef SPI_MASTER_LOOPBACK_EN
    .i_loopback(lb0),
`endif
    .o_busy(busy0), .o_done(done0), .o_rx_data(rx0), .o_spi_cs(cs0),
    .o_spi_sclk(sclk0), .o_spi_mosi(mosi0), .i_spi_miso(miso0)
  );

  spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_tx_data(tx1),
`ifdef SPI_MASTER_LOOPBACK_EN
    .i_loopback(lb1),
`endif
    .o_busy(busy1), .o_done(done1), .o_rx_data(rx1), .o_spi_cs(cs1),
    .o_spi_sclk(sclk1), .o_spi_mosi(mosi1), .i_spi_miso(miso1)
  );

  // Slave word loads on CS fall and shifts on SCLK fall; monitor records MOSI
  // at each SCLK rise, and counts rises and done pulses.
  logic [7:0]  sw0 = 8'h00, sh0 = 8'h00, mw0 = 8'h00;
  int unsigned rises0 = 0, dones0 = 0;
  logic        cs0_p = 1'b1, sclk0_p = 1'b0;
  always @(negedge clk) begin
    if (cs0_p && !cs0) sh0 = sw0;
    else if (!cs0 && sclk0_p && !sclk0) sh0 = {sh0[6:0], 1'b0};
    miso0 = sh0[7];
    if (sclk0 && !sclk0_p) begin
      rises0++;
      mw0 = {mw0[6:0], mosi0};
    end
    if (done0) dones0++;
    cs0_p   = cs0;
    sclk0_p = sclk0;
  end

  logic [7:0]  sw1 = 8'h00, sh1 = 8'h00, mw1 = 8'h00;
  int unsigned dones1 = 0;
  logic        cs1_p = 1'b1, sclk1_p = 1'b0;
  always @(negedge clk) begin
    if (cs1_p && !cs1) sh1 = sw1;
    else if (!cs1 && sclk1_p && !sclk1) sh1 = {sh1[6:0], 1'b0};
    miso1 = sh1[7];
    if (sclk1 && !sclk1_p) mw1 = {mw1[6:0], mosi1};
    if (done1) dones1++;
    cs1_p   = cs1;
    sclk1_p = sclk1;
  end

  task automatic test_reset();
    rst0 = 1'b0; rst1 = 1'b0; start0 = 1'b1; start1 = 1'b1; tx0 = 8'hFF; tx1 = 8'hFF;
    repeat (3) @(negedge clk);
    vectors++;
    if (cs0 !== 1'b1 || sclk0 !== 1'b0 || mosi0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bus: cs/sclk/mosi=%b%b%b required 100", cs0, sclk0, mosi0);
    end
    vectors++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || rx0 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_status: busy=%b done=%b rx=%h required 0 0 00", busy0, done0, rx0);
    end
    vectors++;
    if (cs1 !== 1'b1 || busy1 !== 1'b0 || sclk1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dut1: cs=%b busy=%b sclk=%b required 1 0 0", cs1, busy1, sclk1);
    end
    start0 = 1'b0; start1 = 1'b0; rst0 = 1'b1; rst1 = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start_ignored: busy0=%b busy1=%b required 0 0", busy0, busy1);
    end
  endtask

  // One frame on the default instance. inj: edge offset at which a stray
  // start (tx=FF) is pulsed, 0 for none. sid: pulse start during DONE.
  task automatic run_frame(input string name, input logic [7:0] tx, input logic [7:0] sw,
                           input logic [7:0] exp_rx, input int unsigned inj, input bit sid);
    int unsigned n;
    bit          seen;
    @(negedge clk);
    sw0 = sw; rises0 = 0; dones0 = 0; mw0 = 8'h00;
    tx0 = tx; start0 = 1'b1; n = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    vectors++;
    if (cs0 !== 1'b0 || busy0 !== 1'b1 || sclk0 !== 1'b0 || mosi0 !== tx[7]) begin
      miscompares++;
      $display("FAIL %s_setup: cs=%b busy=%b sclk=%b mosi=%b required 0 1 0 %b",
               name, cs0, busy0, sclk0, mosi0, tx[7]);
    end
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      tx0    = 8'($urandom);
      start0 = (inj != 0) && (cyc + 1 == n + inj);
      if (start0) tx0 = 8'hFF;
      @(negedge clk);
      seen = (done0 === 1'b1);
    end
    vectors++;
    if (!seen || (cyc - n) != EXP0) begin
      miscompares++;
      $display("FAIL %s_done_latency: seen=%0d latency=%0d required %0d", name, seen, cyc - n, EXP0);
    end
    vectors++;
    if (rx0 !== exp_rx) begin
      miscompares++;
      $display("FAIL %s_rx: got %h required %h", name, rx0, exp_rx);
    end
    vectors++;
    if (mw0 !== tx || rises0 != 8) begin
      miscompares++;
      $display("FAIL %s_mosi: bits %h rises %0d required %h 8", name, mw0, rises0, tx);
    end
    vectors++;
    if (cs0 !== 1'b1 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done_bus: cs=%b busy=%b required 1 0", name, cs0, busy0);
    end
    start0 = sid;
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (dones0 != 1 || busy0 !== 1'b0 || rx0 !== exp_rx) begin
      miscompares++;
      $display("FAIL %s_after: dones=%0d busy=%b rx=%h required 1 0 %h", name, dones0, busy0, rx0, exp_rx);
    end
  endtask

  task automatic test_reset_midframe();
    int unsigned edges;
    logic        prev;
    @(negedge clk);
    sw0 = 8'hFF; tx0 = 8'($urandom); start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    edges = 0; prev = sclk0;
    for (int t = 0; t < 200 && edges < 4; t++) begin
      @(negedge clk);
      if (sclk0 !== prev) edges++;
      prev = sclk0;
    end
    vectors++;
    if (edges != 4) begin
      miscompares++;
      $display("FAIL midrst_edges: got %0d sclk edges required 4", edges);
    end
    rst0 = 1'b0;
    @(negedge clk);
    vectors++;
    if (cs0 !== 1'b1 || sclk0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || rx0 !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_state: cs=%b sclk=%b busy=%b done=%b rx=%h required 1 0 0 0 00",
               cs0, sclk0, busy0, done0, rx0);
    end
    rst0 = 1'b1; rises0 = 0; dones0 = 0;
    repeat (100) @(negedge clk);
    vectors++;
    if (rises0 != 0 || dones0 != 0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_quiet: rises=%0d dones=%0d busy=%b required 0 0 0", rises0, dones0, busy0);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned n, d;
    bit          seen;
    @(negedge clk);
    sw1 = 8'h5A; mw1 = 8'h00; dones1 = 0;
    tx1 = 8'h81; start1 = 1'b1; n = cyc + 1;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = (done1 === 1'b1);
    end
    vectors++;
    if (!seen || (cyc - n) != EXP1 || rx1 !== 8'h5A || mw1 !== 8'h81) begin
      miscompares++;
      $display("FAIL b2b_first: seen=%0d latency=%0d rx=%h mosi=%h required 1 %0d 5a 81",
               seen, cyc - n, rx1, mw1, EXP1);
    end
    d = cyc; tx1 = 8'h7E; sw1 = 8'hC6; mw1 = 8'h00;
    @(negedge clk);
    vectors++;
    if (cs1 !== 1'b1 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle_gap: cs=%b busy=%b required 1 0", cs1, busy1);
    end
    @(negedge clk);
    vectors++;
    if (cs1 !== 1'b0 || busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: cs=%b busy=%b required 0 1", cs1, busy1);
    end
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = (done1 === 1'b1);
    end
    start1 = 1'b0;
    vectors++;
    if (!seen || cyc != d + 2 + EXP1 || rx1 !== 8'hC6 || mw1 !== 8'h7E) begin
      miscompares++;
      $display("FAIL b2b_second: seen=%0d cyc=%0d rx=%h mosi=%h required 1 %0d c6 7e",
               seen, cyc, rx1, mw1, d + 2 + EXP1);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (dones1 != 2 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_count: dones=%0d busy=%b required 2 0", dones1, busy1);
    end
  endtask

  initial begin
    logic [7:0] rt, rs;
    test_reset();
    run_frame("basic_a5", 8'hA5, 8'h3C, 8'h3C, 0, 1'b0);
    run_frame("ignore_start", 8'h96, 8'h69, 8'h69, 10, 1'b0);
    run_frame("start_in_done", 8'h5C, 8'hE1, 8'hE1, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      rt = 8'($urandom);
      rs = 8'($urandom) | 8'h01;
      run_frame("random", rt, rs, rs, 0, 1'b0);
    end
    test_reset_midframe();
    test_back_to_back();
`ifdef SPI_MASTER_LOOPBACK_EN
    lb0 = 1'b1;
    run_frame("loopback", 8'hC3, 8'h00, 8'hC3, 0, 1'b0);
    lb0 = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per frame.
REQ-002 SHALL have parameter CLK_DIV, default 4, i_clk cycles per SCLK half-period; legal range 1..255.
REQ-003 SHALL have port i_clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_start  input  1  transfer request; sampled in IDLE only.
REQ-006 SHALL have port i_tx_data  input  DATA_WIDTH  word to send; captured when i_start is accepted.
REQ-007 SHALL have port o_busy  output  1  frame in progress.
REQ-008 SHALL have port o_done  output  1  one-cycle pulse, frame complete.
REQ-009 SHALL have port o_rx_data  output  DATA_WIDTH  last received word.
REQ-010 SHALL have port o_spi_cs  output  1  chip select, active-low.
REQ-011 SHALL have port o_spi_sclk  output  1  serial clock to slave.
REQ-012 SHALL have port o_spi_mosi  output  1  serial data to slave, MSB first.
REQ-013 SHALL have port i_spi_miso  input  1  serial data from slave.

Function
REQ-014 SHALL implement SPI mode 0: SCLK idles low, MISO sampled on SCLK rising edge, MOSI changes on SCLK falling edge.
REQ-015 SHALL use FSM states IDLE, SETUP, XFER, HOLD, DONE.
REQ-016 IDLE: cs=1, sclk=0, busy=0; i_start=1 at edge N -> SETUP, tx word loaded into shift register, bit counter cleared.
REQ-017 SETUP: from cycle N+1, cs=0, busy=1, mosi=tx[DATA_WIDTH-1]; lasts CLK_DIV cycles, sclk=0.
REQ-018 XFER: sclk toggles every CLK_DIV cycles for exactly DATA_WIDTH full periods; on each rising edge MISO shifts into rx register LSB; on each falling edge except the last, MOSI advances to next lower bit.
REQ-019 HOLD: sclk=0, cs=0, mosi held; lasts CLK_DIV cycles.
REQ-020 DONE: exactly one cycle; cs=1, busy=0, o_done=1, o_rx_data updated from rx register; next state IDLE.
REQ-021 o_done SHALL first be high at cycle N+1+CLK_DIV*(2*DATA_WIDTH+2) (N+73 for defaults).
REQ-022 i_start while busy or in DONE SHALL be ignored, with no queuing.
REQ-023 i_tx_data changes after acceptance SHALL NOT affect the frame in progress.
REQ-024 o_rx_data SHALL hold its value between o_done pulses.
REQ-025 Bit and divider counters SHALL saturate/wrap only within their frame; no count carries across frames.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 i_rst=0 at an edge SHALL force IDLE, cs=1, sclk=0, mosi=0, busy=0, done=0, o_rx_data=0 by the next cycle.
REQ-028 Reset mid-frame SHALL abort with no o_done pulse, and no SCLK edge after the reset edge.
REQ-029 i_start asserted during reset SHALL be ignored.

Configuration
REQ-030 Macro SPI_MASTER_LOOPBACK_EN, when defined, SHALL add input i_loopback (1 bit); i_loopback=1 makes the rx path sample o_spi_mosi instead of i_spi_miso.
REQ-031 Without SPI_MASTER_LOOPBACK_EN, port i_loopback SHALL be absent and rx SHALL always sample i_spi_miso.

Verification
REQ-032 Defaults, tx=0xA5, slave model returns 0x3C -> MOSI bit sequence 1,0,1,0,0,1,0,1; o_rx_data=0x3C; o_done at N+73; exactly 8 SCLK rising edges.
REQ-033 i_start pulsed at N+10 during a frame with tx=0xFF -> ignored; first frame completes unchanged; exactly one o_done pulse.
REQ-034 i_rst=0 at SCLK edge 4 of a frame -> next cycle cs=1, sclk=0, busy=0; no o_done; o_rx_data=0.
REQ-035 CLK_DIV=1, i_start held high for two frames with tx=0x81 then 0x7E -> second frame starts at the first IDLE cycle after DONE; cs deasserted for at least the DONE cycle between frames.
REQ-036 SPI_MASTER_LOOPBACK_EN defined, i_loopback=1, tx=0xC3, i_spi_miso tied to 0 -> o_rx_data=0xC3.
